latent_frame_rx: RTL and testbench

//  Receive end of the HGCAL autoencoder latent link. The encoder's final LUT layer emits

---
 rtl/latent_frame_rx.sv | 159 +++++++++++++++
 tb/tb_latent_frame_rx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/latent_frame_rx.sv
// latent_frame_rx: receive end of the latent-code link.
// Reassembles WPF link words (LSB-first, word w at bits [w*LINK_W +: LINK_W])
// into one frame and hands it to the decoder over a valid/ready handshake.
// Optional build macro: LATENT_RX_PARITY_EN enables even-parity checking of
// every accepted word (^{s_data_i, s_par_i} must be 0); bad frames are dropped.
//
// state | meaning
// IDLE  | waiting for a start-of-frame word
// ASM   | collecting words 1..WPF-1 into the assembly register
// FULL  | frame complete, waiting for the output register to free up
module latent_frame_rx #(
  parameter int N_LATENT = 16,
  parameter int CODE_W   = 2,
  parameter int LINK_W   = 8,
  parameter int CNT_W    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [LINK_W-1:0]            s_data_i,
  input  logic                         s_sof_i,
  input  logic                         s_par_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [N_LATENT*CODE_W-1:0]   m_data_o,
  output logic                         err_pulse_o,
  output logic [CNT_W-1:0]             err_cnt_o
);

  localparam int FRAME_W = N_LATENT * CODE_W;
  localparam int WPF     = FRAME_W / LINK_W;
  localparam int IDX_W   = (WPF > 1) ? $clog2(WPF) : 1;

  typedef enum logic [1:0] {IDLE, ASM, FULL} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic [FRAME_W-1:0] m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               bad_q, bad_d;
  logic               err_pulse_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [FRAME_W-1:0] frame_c;
  logic               acc, out_free, done_c, par_bad;

`ifdef LATENT_RX_PARITY_EN
  assign par_bad = ^{s_data_i, s_par_i};
`else
  logic unused_par;
  assign unused_par = s_par_i;
  assign par_bad    = 1'b0;
`endif

  assign s_ready_o   = (state_q != FULL);
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;

  // Next-state, assembly and output-register loading
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    done_c    = 1'b0;
    frame_c   = asm_q;
    acc       = s_valid_i & s_ready_o;
    out_free  = ~m_valid_q | m_ready_i;
    // a pop with nothing new to load empties the output register
    m_valid_d = m_valid_q & ~m_ready_i;
    m_data_d  = m_data_q;

    case (state_q)
      IDLE: begin
        if (acc) begin
          if (s_sof_i) begin
            frame_c[0 +: LINK_W] = s_data_i;
            bad_d = par_bad;
            err_d = par_bad;
            idx_d = (WPF > 1) ? IDX_W'(1) : '0;
            if (WPF == 1) done_c = 1'b1;
            else          state_d = ASM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ASM: begin
        if (acc) begin
          if (s_sof_i) begin
            // restart: the partial frame is abandoned, one error pulse
            frame_c[0 +: LINK_W] = s_data_i;
            idx_d = IDX_W'(1);
            bad_d = par_bad;
            err_d = 1'b1;
          end else begin
            frame_c[idx_q*LINK_W +: LINK_W] = s_data_i;
            idx_d = idx_q + 1'b1;
            bad_d = bad_q | par_bad;
            err_d = par_bad;
            if (idx_q == IDX_W'(WPF - 1)) done_c = 1'b1;
          end
        end
      end
      FULL: begin
        if (out_free) begin
          m_data_d  = asm_q;
          m_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    asm_d = frame_c;

    // completion: fast path straight into the output register when it is free
    if (done_c) begin
      idx_d   = '0;
      state_d = IDLE;
      if (!bad_d) begin
        if (out_free) begin
          m_data_d  = frame_c;
          m_valid_d = 1'b1;
        end else begin
          state_d = FULL;
        end
      end
    end
  end

  // State, datapath and error-counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      asm_q       <= '0;
      bad_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      bad_q       <= bad_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      err_pulse_q <= err_d;
      if (err_d && (err_cnt_q != {CNT_W{1'b1}}))
        err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_latent_frame_rx.sv
// tb_latent_frame_rx: directed and randomized checks of latent_frame_rx
// against a frame-level reference model (word queue + output slot).
module tb_latent_frame_rx;

  localparam int N_LATENT = 16;
  localparam int CODE_W   = 2;
  localparam int LINK_W   = 8;
  localparam int CNT_W    = 8;
  localparam int FRAME_W  = N_LATENT * CODE_W;
  localparam int WPF      = FRAME_W / LINK_W;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               s_valid_i;
  logic               s_ready_o;
  logic [LINK_W-1:0]  s_data_i;
  logic               s_sof_i;
  logic               s_par_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [FRAME_W-1:0] m_data_o;
  logic               err_pulse_o;
  logic [CNT_W-1:0]   err_cnt_o;

  latent_frame_rx #(
    .N_LATENT(N_LATENT), .CODE_W(CODE_W), .LINK_W(LINK_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_sof_i(s_sof_i), .s_par_i(s_par_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .err_pulse_o(err_pulse_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: words of the frame in progress, one pending frame, the output slot
  logic [LINK_W-1:0]  cur[$];
  bit                 cur_bad;
  bit                 pend_v;
  logic [FRAME_W-1:0] pend_d;
  bit                 out_v;
  logic [FRAME_W-1:0] out_d;
  bit                 exp_err;
  int                 exp_cnt;
  bit                 mr;
  int                 gen_pos;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    cur.delete();
    cur_bad = 0; pend_v = 0; pend_d = '0;
    out_v = 0; out_d = '0; exp_err = 0; exp_cnt = 0;
  endtask

  task automatic compare();
    chk("s_ready",   64'(s_ready_o),   64'(!pend_v));
    chk("m_valid",   64'(m_valid_o),   64'(out_v));
    chk("m_data",    64'(m_data_o),    64'(out_d));
    chk("err_pulse", 64'(err_pulse_o), 64'(exp_err));
    chk("err_cnt",   64'(err_cnt_o),   64'(exp_cnt));
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [LINK_W-1:0] d,
                            input bit p, input bit rdy);
    bit acc, par_ok, have_new;
    logic [FRAME_W-1:0] nf;
    acc = v && !pend_v;
    par_ok = 1; have_new = 0; nf = '0; exp_err = 0;
    if (acc) begin
`ifdef LATENT_RX_PARITY_EN
      par_ok = (((^d) ^ p) == 1'b0);
`endif
      if (sof) begin
        if (cur.size() != 0) exp_err = 1;
        cur.delete();
        cur.push_back(d);
        cur_bad = !par_ok;
        if (!par_ok) exp_err = 1;
      end else if (cur.size() == 0) begin
        exp_err = 1;
      end else begin
        cur.push_back(d);
        if (!par_ok) begin exp_err = 1; cur_bad = 1; end
      end
      if (cur.size() == WPF) begin
        if (!cur_bad) begin
          have_new = 1;
          for (int i = 0; i < WPF; i++) nf |= FRAME_W'(cur[i]) << (i * LINK_W);
        end
        cur.delete();
      end
    end
    if (pend_v) begin have_new = 1; nf = pend_d; end
    if (have_new && (!out_v || rdy)) begin out_v = 1; out_d = nf; pend_v = 0; end
    else if (have_new)               begin pend_v = 1; pend_d = nf; end
    else if (out_v && rdy)           out_v = 0;
    if (exp_err && exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  // one clock: check outputs, drive inputs, advance model, move to the next falling edge
  task automatic step(input bit v, input bit sof, input logic [LINK_W-1:0] d, input bit p);
    compare();
    s_valid_i = v; s_sof_i = sof; s_data_i = d; s_par_i = p; m_ready_i = mr;
    model_step(v, sof, d, p, mr);
    @(negedge clk_i);
  endtask

  task automatic word(input bit sof, input logic [LINK_W-1:0] d);
    step(1, sof, d, ^d);
  endtask

  task automatic idle();
    step(0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1; s_valid_i = 0; s_sof_i = 0; s_data_i = '0; s_par_i = 0; m_ready_i = 0;
    @(negedge clk_i);
    rst_i = 0;
    model_reset();
    gen_pos = 0;
  endtask

  task automatic random_phase(input int cycles, input int pv, input int pr);
    bit v, sof, p, acc;
    logic [LINK_W-1:0] d;
    for (int i = 0; i < cycles; i++) begin
      v   = ($urandom_range(0, 99) < pv);
      mr  = ($urandom_range(0, 99) < pr);
      sof = (gen_pos == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 19) == 0);
      d   = LINK_W'($urandom);
      p   = (^d) ^ ($urandom_range(0, 29) == 0);
      acc = v && !pend_v;
      step(v, sof, d, p);
      if (acc) gen_pos = sof ? 1 : ((gen_pos + 1) % WPF);
    end
  endtask

  initial begin
    mr = 0;
    do_reset();
    do_reset();
    chk("rst_ready", 64'(s_ready_o), 64'd1);
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_data",  64'(m_data_o),  64'd0);
    chk("rst_cnt",   64'(err_cnt_o), 64'd0);

    // basic frame, fast path
    mr = 1;
    word(1, 8'h1B); word(0, 8'hE4); word(0, 8'h00); word(0, 8'hFF);
    chk("ex_valid", 64'(m_valid_o), 64'd1);
    chk("ex_data",  64'(m_data_o),  64'hFF00E41B);
    idle();

    // two frames with m_ready low: second one parks in FULL
    mr = 0;
    word(1, 8'h11); word(0, 8'h22); word(0, 8'h33); word(0, 8'h44);
    word(1, 8'h55); word(0, 8'h66); word(0, 8'h77); word(0, 8'h88);
    chk("bp_ready", 64'(s_ready_o), 64'd0);
    chk("bp_a",     64'(m_data_o),  64'h44332211);
    mr = 1;
    idle();
    chk("bp_b_valid", 64'(m_valid_o), 64'd1);
    chk("bp_b",       64'(m_data_o),  64'h88776655);
    idle();
    chk("bp_drain", 64'(m_valid_o), 64'd0);

    // sof in the middle of a frame
    do_reset();
    mr = 1;
    word(1, 8'h01); word(0, 8'h02); word(1, 8'hA1);
    chk("sof_err", 64'(err_pulse_o), 64'd1);
    chk("sof_cnt", 64'(err_cnt_o),   64'd1);
    word(0, 8'hA2); word(0, 8'hA3); word(0, 8'hA4);
    chk("sof_data", 64'(m_data_o), 64'hA4A3A2A1);

    // stray word while idle
    word(0, 8'h5A);
    chk("drop_err",   64'(err_pulse_o), 64'd1);
    chk("drop_valid", 64'(m_valid_o),   64'd0);
    chk("drop_cnt",   64'(err_cnt_o),   64'd2);

`ifdef LATENT_RX_PARITY_EN
    do_reset();
    mr = 1;
    word(1, 8'h10);
    step(1, 0, 8'h20, ~(^8'h20));
    chk("par_err", 64'(err_pulse_o), 64'd1);
    word(0, 8'h30); word(0, 8'h40);
    chk("par_drop", 64'(m_valid_o), 64'd0);
    word(1, 8'h01); word(0, 8'h02); word(0, 8'h03); word(0, 8'h04);
    chk("par_next", 64'(m_data_o), 64'h04030201);
    idle();
`endif

    // error counter saturation
    for (int i = 0; i < 300; i++) word(0, LINK_W'($urandom));
    chk("sat_cnt", 64'(err_cnt_o), 64'(CNT_MAX));
    idle();

    // randomized traffic against the model
    do_reset();
    random_phase(700, 90, 90);
    random_phase(700, 70, 30);
    random_phase(700, 100, 100);

    // reset in the middle of a frame with a frame held at the output
    mr = 0;
    for (int i = 0; i < 6; i++) idle();
    word(1, 8'hC1); word(0, 8'hC2); word(0, 8'hC3); word(0, 8'hC4);
    word(1, 8'hD1); word(0, 8'hD2);
    do_reset();
    chk("mid_ready", 64'(s_ready_o),   64'd1);
    chk("mid_valid", 64'(m_valid_o),   64'd0);
    chk("mid_data",  64'(m_data_o),    64'd0);
    chk("mid_err",   64'(err_pulse_o), 64'd0);
    chk("mid_cnt",   64'(err_cnt_o),   64'd0);
    mr = 1;
    word(1, 8'hE1); word(0, 8'hE2); word(0, 8'hE3); word(0, 8'hE4);
    chk("post_rst", 64'(m_data_o), 64'hE4E3E2E1);
    idle();
    compare();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
